// File: rtl/segre_store_buffer.sv
// Store buffer between the TL stage and the data cache: circular FIFO of pending
// stores with same-address coalescing, load forwarding/hazard detection and drain.
module segre_store_buffer #(
    parameter int NUM_ELEMS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_store_i,
    input  logic        req_load_i,
    input  logic        flush_chance_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  memop_data_type_i,
    output logic        hit_o,
    output logic        miss_o,
    output logic        trouble_o,
    output logic        full_o,
    output logic        data_valid_o,
    output logic [1:0]  memop_data_type_o,
    output logic [31:0] data_o,
    output logic [31:0] addr_o
);

    localparam int PW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int CW = $clog2(NUM_ELEMS + 1);
    localparam logic [1:0] BYTE = 2'd0;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  dtype;
    } entry_t;

    entry_t          buf_q [NUM_ELEMS];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    logic            pop, alloc, coalesce;
    logic            ovl_any, cl_any;
    logic [PW-1:0]   ovl_idx, cl_idx;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_ELEMS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o       = (count_q == CW'(NUM_ELEMS));
    assign pop          = flush_chance_i && (count_q != '0) && !req_load_i;
    assign data_valid_o = pop;

    // Walk oldest to youngest so the last match recorded is the youngest one.
    always_comb begin
        int          j;
        logic [PW-1:0] jj;
        ovl_any = 1'b0;
        ovl_idx = '0;
        cl_any  = 1'b0;
        cl_idx  = '0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            j = int'(head_q) + i;
            if (j >= NUM_ELEMS) j = j - NUM_ELEMS;
            jj = PW'(j);
            if (buf_q[jj].valid && buf_q[jj].addr[31:2] == addr_i[31:2]) begin
                ovl_any = 1'b1;
                ovl_idx = jj;
            end
            // The head entry leaving this cycle cannot absorb a new store.
            if (buf_q[jj].valid && buf_q[jj].addr == addr_i &&
                buf_q[jj].dtype == memop_data_type_i && !(pop && jj == head_q)) begin
                cl_any = 1'b1;
                cl_idx = jj;
            end
        end
    end

    assign coalesce = req_store_i && cl_any;
    assign alloc    = req_store_i && !cl_any && ((count_q != CW'(NUM_ELEMS)) || pop);

    assign hit_o     = req_load_i && ovl_any && buf_q[ovl_idx].addr == addr_i &&
                       buf_q[ovl_idx].dtype == memop_data_type_i;
    assign trouble_o = req_load_i && ovl_any && !hit_o;
    assign miss_o    = req_load_i && !ovl_any;

    always_comb begin
        data_o            = '0;
        addr_o            = '0;
        memop_data_type_o = BYTE;
        if (hit_o) begin
            data_o            = buf_q[ovl_idx].data;
            addr_o            = buf_q[ovl_idx].addr;
            memop_data_type_o = buf_q[ovl_idx].dtype;
        end else if (pop) begin
            data_o            = buf_q[head_q].data;
            addr_o            = buf_q[head_q].addr;
            memop_data_type_o = buf_q[head_q].dtype;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) buf_q[i].valid <= 1'b0;
        end else begin
            if (pop) begin
                buf_q[head_q].valid <= 1'b0;
                head_q              <= wrap_inc(head_q);
            end
            // Allocate comes after pop so a full-buffer replace keeps the slot valid.
            if (coalesce) begin
                buf_q[cl_idx].data <= data_i;
            end else if (alloc) begin
                buf_q[tail_q] <= '{valid: 1'b1, addr: addr_i, data: data_i,
                                   dtype: memop_data_type_i};
                tail_q        <= wrap_inc(tail_q);
            end
            if (alloc && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !alloc) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: doc/segre_store_buffer.md
SEGRE_STORE_BUFFER -- requirements
Module: segre_store_buffer

Interface
REQ-001 The block SHALL have parameter NUM_ELEMS, default 2, giving the number of buffered stores.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the only clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_store_i, input, 1 bit: TL stage requests a store be buffered.
REQ-005 The block SHALL have port req_load_i, input, 1 bit: TL stage requests a load lookup.
REQ-006 The block SHALL have port flush_chance_i, input, 1 bit: the data cache is free this cycle to accept one drained store.
REQ-007 The block SHALL have port addr_i, input, 32 bits: the memop byte address.
REQ-008 The block SHALL have port data_i, input, 32 bits: the store data.
REQ-009 The block SHALL have port memop_data_type_i, input, 2 bits: the memop size, encoded BYTE=0, HALF=1, WORD=2.
REQ-010 The block SHALL have port hit_o, output, 1 bit: the load is fully served by the buffer.
REQ-011 The block SHALL have port miss_o, output, 1 bit: the load does not overlap any buffered store.
REQ-012 The block SHALL have port trouble_o, output, 1 bit: the load partially overlaps a buffered store, and TL must stall.
REQ-013 The block SHALL have port full_o, output, 1 bit: all NUM_ELEMS entries are valid.
REQ-014 The block SHALL have port data_valid_o, output, 1 bit: a drained store is presented to the data cache.
REQ-015 The block SHALL have port memop_data_type_o, output, 2 bits: the size of the presented entry.
REQ-016 The block SHALL have port data_o, output, 32 bits: the hit data or the drained data.
REQ-017 The block SHALL have port addr_o, output, 32 bits: the address of the presented entry.

Function
REQ-018 The storage SHALL be a circular FIFO of NUM_ELEMS entries {valid, addr, data, type}, with head, tail and count pointers; head and tail wrap from NUM_ELEMS-1 to 0.
REQ-019 full_o SHALL be asserted when count==NUM_ELEMS; the buffer is empty when count==0.
REQ-020 Lookup SHALL be combinational on registered state only; a store written in the same cycle is not visible to that cycle's lookup.
REQ-021 Store coalesce: when req_store_i, a valid entry has addr==addr_i and type==memop_data_type_i, and that entry is not being popped this cycle, the entry's data SHALL be overwritten at the clock edge and count SHALL be unchanged.
REQ-022 Store allocate: otherwise, when count<NUM_ELEMS or a pop occurs in the same cycle, the entry at tail SHALL be written at the clock edge and tail SHALL advance.
REQ-023 A store with full_o=1 and no same-cycle pop SHALL be dropped with no state change; TL guarantees this never occurs, and the bench asserts it never occurs.
REQ-024 Load lookup, when req_load_i=1: "overlap" means entry.addr[31:2]==addr_i[31:2].
REQ-025 hit_o SHALL be 1 when the youngest overlapping entry has exact addr and type equality; data_o SHALL then carry that entry's data.
REQ-026 trouble_o SHALL be 1 when any entry overlaps and hit_o=0.
REQ-027 miss_o SHALL be 1 when no entry overlaps.
REQ-028 Exactly one of hit_o, trouble_o and miss_o SHALL be 1 when req_load_i=1; all three SHALL be 0 when req_load_i=0.
REQ-029 Drain: data_valid_o SHALL equal flush_chance_i && count>0 && !req_load_i, and SHALL be combinational.
REQ-030 While data_valid_o=1, addr_o, data_o and memop_data_type_o SHALL show the head entry, and head SHALL advance at the clock edge (pop); the consumer accepts unconditionally.
REQ-031 Output mux priority for data_o, addr_o and memop_data_type_o SHALL be: load hit, then drain, then zeros/BYTE.
REQ-032 Count update SHALL be: +1 on allocate without pop; -1 on pop without allocate; unchanged on allocate+pop or on coalesce.
REQ-033 Simultaneous req_store_i and req_load_i SHALL process the store; the load result reflects pre-store state.
REQ-034 The pipeline SHALL hold req_* low while a hazard is flagged; the block has no internal FSM beyond the FIFO pointers.

Reset
REQ-035 With rst_i=1 at a clock edge, head, tail and count SHALL be set to 0 and all valid bits cleared; this discards any in-flight entries, including during a drain.
REQ-036 After reset, and while rst_i=1, full_o, data_valid_o, hit_o, trouble_o and miss_o SHALL be 0; data_o and addr_o SHALL be 0; memop_data_type_o SHALL be BYTE (given req_load_i=0).

Verification
REQ-037 Store WORD 0x100=0xDEADBEEF, then load WORD 0x100 -> hit_o=1, data_o=0xDEADBEEF, miss_o=0, trouble_o=0.
REQ-038 Store BYTE 0x101=0xAA, then load WORD 0x100 -> trouble_o=1; load WORD 0x200 -> miss_o=1.
REQ-039 Stores WORD to 0x10 then 0x20 -> full_o=1; then flush_chance_i=1 for 2 cycles -> data_valid_o=1 with addr_o=0x10, then addr_o=0x20; then full_o=0 and count=0.
REQ-040 Full buffer, store to 0x30 with flush_chance_i=1 in the same cycle -> pop of 0x10 and allocate of 0x30; full_o stays 1; next drain shows 0x20.
REQ-041 Store WORD 0x40=1, then store WORD 0x40=2 -> count=1; load 0x40 -> data_o=2.
REQ-042 Two entries valid, rst_i=1 for 1 cycle -> full_o=0, flush_chance_i=1 gives data_valid_o=0, load 0x10 -> miss_o=1.
